// File: rtl/hyperbus_target_model.sv
// HyperRAM device responder at the controller's one-word-per-CK boundary.
// Holds a word-addressed memory, the CR0 register and a fixed initial-latency countdown.
module hyperbus_target_model #(
    parameter int          ADDR_W   = 10,
    parameter int          LATENCY  = 6,
    parameter int          FIXED_2X = 1,
    parameter int          WRAP_LEN = 16,
    parameter logic [15:0] ID0      = 16'h0C81,
    parameter logic [15:0] CR0_RST  = 16'h8F1F
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        csn,
    input  logic        ck_en,
    input  logic [15:0] dq_in,
    input  logic [1:0]  rwds_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        rwds_out,
    output logic        rwds_oe,
    output logic [15:0] cr0,
    output logic        proto_err
);

    localparam int              DEPTH     = 1 << ADDR_W;
    localparam int              LAT_CYC   = (FIXED_2X != 0) ? 2 * LATENCY : LATENCY;
    localparam logic [7:0]      LAT_LOAD  = 8'(LAT_CYC);
    localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(WRAP_LEN - 1);
    localparam logic            RWDS_CA   = (FIXED_2X != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CA    = 3'd1,
        S_LAT   = 3'd2,
        S_WR    = 3'd3,
        S_RD    = 3'd4,
        S_REGWR = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]         r_ca_hi;
    logic [1:0]          r_ca_cnt;
    logic [7:0]          r_lat_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_is_read;
    logic                r_is_reg;
    logic                r_linear;
    logic                r_ca0;
    logic                r_reg_done;
    logic [15:0]         r_cr0;
    logic [15:0]         r_dq_out;
    logic                r_dq_oe;
    logic                r_rwds_out;
    logic                r_rwds_oe;
    logic                r_proto_err;
    logic [15:0]         r_mem [DEPTH];

    logic                w_beat;
    logic                w_ca_last;
    logic [47:0]         w_ca;
    logic [31:0]         w_start_full;
    logic [ADDR_W-1:0]   w_start_addr;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [15:0]         w_rd_word;
    logic [15:0]         w_dq_out_nxt;
    logic                w_dq_oe_nxt;
    logic                w_rwds_out_nxt;
    logic                w_rwds_oe_nxt;
    logic                w_proto_err_nxt;
    logic                w_unused_bits;

    assign w_beat       = ~csn & ck_en;
    // The third CA word is still on dq_in when the command is decoded.
    assign w_ca         = {r_ca_hi, dq_in};
    assign w_ca_last    = (r_state == S_CA) && w_beat && (r_ca_cnt == 2'd2);
    assign w_start_full = {w_ca[44:16], w_ca[2:0]};
    assign w_start_addr = w_start_full[ADDR_W-1:0];
    assign w_addr_inc   = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_addr_nxt   = r_linear ? w_addr_inc
                                   : ((r_addr & ~WRAP_MASK) | (w_addr_inc & WRAP_MASK));
    assign w_rd_word    = r_is_reg ? (r_ca0 ? r_cr0 : ID0) : r_mem[r_addr];
    assign w_unused_bits = ^{w_start_full[31:ADDR_W], w_ca[15:3]};

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; csn high always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (csn) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_CA;
                S_CA: begin
                    if (w_ca_last) begin
                        if (w_ca[47]) begin
                            w_state_nxt = S_LAT;
                        end else if (w_ca[46]) begin
                            w_state_nxt = S_REGWR;
                        end else begin
                            w_state_nxt = S_LAT;
                        end
                    end else begin
                        w_state_nxt = S_CA;
                    end
                end
                S_LAT: begin
                    if (w_beat && (r_lat_cnt == 8'd1)) begin
                        w_state_nxt = r_is_read ? S_RD : S_WR;
                    end else begin
                        w_state_nxt = S_LAT;
                    end
                end
                S_WR, S_RD, S_REGWR: w_state_nxt = r_state;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs
    always_comb begin
        w_dq_out_nxt    = r_dq_out;
        w_dq_oe_nxt     = 1'b0;
        w_rwds_out_nxt  = 1'b0;
        w_rwds_oe_nxt   = 1'b0;
        w_proto_err_nxt = 1'b0;
        if (csn) begin
            w_proto_err_nxt = (r_state == S_CA) || (r_state == S_LAT);
        end else begin
            case (w_state_nxt)
                S_CA: begin
                    w_rwds_oe_nxt  = 1'b1;
                    w_rwds_out_nxt = RWDS_CA;
                end
                S_RD: begin
                    w_dq_oe_nxt   = 1'b1;
                    w_rwds_oe_nxt = 1'b1;
                    if ((r_state == S_RD) && w_beat) begin
                        w_dq_out_nxt   = w_rd_word;
                        w_rwds_out_nxt = 1'b1;
                    end else begin
                        w_rwds_out_nxt = 1'b0;
                    end
                end
                default: w_dq_oe_nxt = 1'b0;
            endcase
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dq_out    <= 16'h0000;
            r_dq_oe     <= 1'b0;
            r_rwds_out  <= 1'b0;
            r_rwds_oe   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_dq_out    <= w_dq_out_nxt;
            r_dq_oe     <= w_dq_oe_nxt;
            r_rwds_out  <= w_rwds_out_nxt;
            r_rwds_oe   <= w_rwds_oe_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    // CA capture, latency count, burst address and CR0
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ca_hi    <= 32'h0000_0000;
            r_ca_cnt   <= 2'd0;
            r_lat_cnt  <= 8'd0;
            r_addr     <= '0;
            r_is_read  <= 1'b0;
            r_is_reg   <= 1'b0;
            r_linear   <= 1'b0;
            r_ca0      <= 1'b0;
            r_reg_done <= 1'b0;
            r_cr0      <= CR0_RST;
        end else begin
            case (r_state)
                S_IDLE: r_ca_cnt <= 2'd0;
                S_CA: begin
                    if (w_beat) begin
                        r_ca_cnt <= r_ca_cnt + 2'd1;
                        case (r_ca_cnt)
                            2'd0: r_ca_hi[31:16] <= dq_in;
                            2'd1: r_ca_hi[15:0]  <= dq_in;
                            default: begin
                                r_is_read  <= w_ca[47];
                                r_is_reg   <= w_ca[46];
                                r_linear   <= w_ca[45];
                                r_ca0      <= w_ca[0];
                                r_addr     <= w_start_addr;
                                r_lat_cnt  <= LAT_LOAD;
                                r_reg_done <= 1'b0;
                            end
                        endcase
                    end
                end
                S_LAT: begin
                    if (w_beat) begin
                        r_lat_cnt <= r_lat_cnt - 8'd1;
                    end
                end
                S_RD, S_WR: begin
                    if (w_beat) begin
                        r_addr <= w_addr_nxt;
                    end
                end
                S_REGWR: begin
                    if (w_beat && !r_reg_done) begin
                        r_reg_done <= 1'b1;
                        r_cr0      <= dq_in;
                    end
                end
                default: r_ca_cnt <= r_ca_cnt;
            endcase
        end
    end

    // Byte-masked memory write; contents survive reset
    always_ff @(posedge clk) begin
        if ((r_state == S_WR) && w_beat) begin
            if (!rwds_in[1]) begin
                r_mem[r_addr][15:8] <= dq_in[15:8];
            end
            if (!rwds_in[0]) begin
                r_mem[r_addr][7:0] <= dq_in[7:0];
            end
        end
    end

    assign dq_out    = r_dq_out;
    assign dq_oe     = r_dq_oe;
    assign rwds_out  = r_rwds_out;
    assign rwds_oe   = r_rwds_oe;
    assign cr0       = r_cr0;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_hyperbus_target_model.sv
// Randomized bench for hyperbus_target_model against an array/arithmetic model of the device.
module tb_hyperbus_target_model;

    localparam int          ADDR_W   = 10;
    localparam int          LATENCY  = 6;
    localparam int          FIXED_2X = 1;
    localparam int          WRAP_LEN = 16;
    localparam logic [15:0] ID0      = 16'h0C81;
    localparam logic [15:0] CR0_RST  = 16'h8F1F;
    localparam int          DEPTH    = 1 << ADDR_W;
    localparam int          LAT_CYC  = 12;

    logic        clk = 1'b0;
    logic        rstn;
    logic        csn;
    logic        ck_en;
    logic [15:0] dq_in;
    logic [1:0]  rwds_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic        rwds_out;
    logic        rwds_oe;
    logic [15:0] cr0;
    logic        proto_err;

    logic [15:0] m_mem [DEPTH];
    logic [15:0] m_cr0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    hyperbus_target_model #(
        .ADDR_W(ADDR_W), .LATENCY(LATENCY), .FIXED_2X(FIXED_2X), .WRAP_LEN(WRAP_LEN),
        .ID0(ID0), .CR0_RST(CR0_RST)
    ) u_dut (
        .clk(clk), .rstn(rstn), .csn(csn), .ck_en(ck_en), .dq_in(dq_in), .rwds_in(rwds_in),
        .dq_out(dq_out), .dq_oe(dq_oe), .rwds_out(rwds_out), .rwds_oe(rwds_oe),
        .cr0(cr0), .proto_err(proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int next_addr(input int a, input bit linear);
        if (linear) return (a + 1) % DEPTH;
        return (a - (a % WRAP_LEN)) + (((a % WRAP_LEN) + 1) % WRAP_LEN);
    endfunction

    function automatic logic [47:0] make_ca(input bit rd, input bit rg, input bit lin, input logic [31:0] a);
        logic [47:0] c;
        c        = '0;
        c[47]    = rd;
        c[46]    = rg;
        c[45]    = lin;
        c[44:16] = a[31:3];
        c[2:0]   = a[2:0];
        return c;
    endfunction

    function automatic int ca_addr(input logic [47:0] ca);
        logic [31:0] s;
        s = {ca[44:16], ca[2:0]};
        return int'(s % DEPTH);
    endfunction

    task automatic stall(input int n);
        ck_en   = 1'b0;
        dq_in   = 16'($urandom);
        rwds_in = 2'($urandom);
        repeat (n) tick();
        ck_en = 1'b1;
    endtask

    task automatic send_ca(input logic [47:0] ca);
        csn   = 1'b0;
        ck_en = 1'b1;
        tick();
        chk("ca_rwds_oe", rwds_oe, 1);
        chk("ca_rwds_out", rwds_out, FIXED_2X);
        for (int i = 0; i < 3; i++) begin
            dq_in = ca[47 - 16 * i -: 16];
            tick();
        end
    endtask

    task automatic latency(input bit stalls);
        for (int i = 0; i < LAT_CYC; i++) begin
            if (stalls && ($urandom_range(0, 5) == 0)) stall($urandom_range(1, 3));
            dq_in   = 16'($urandom);
            rwds_in = 2'($urandom);
            tick();
            if (i == LAT_CYC - 2) chk("lat_not_done", dq_oe, 0);
        end
    endtask

    task automatic end_txn();
        csn   = 1'b1;
        ck_en = 1'($urandom);
        tick();
        chk("end_dq_oe", dq_oe, 0);
        chk("end_rwds_oe", rwds_oe, 0);
        chk("end_rwds_out", rwds_out, 0);
        chk("end_proto_err", proto_err, 0);
        ck_en = 1'b1;
    endtask

    task automatic do_write(input logic [47:0] ca, input logic [15:0] dq[$], input logic [1:0] mq[$],
                            input bit stalls);
        int a;
        a = ca_addr(ca);
        send_ca(ca);
        if (!ca[46]) latency(stalls);
        for (int i = 0; i < dq.size(); i++) begin
            if (stalls && ($urandom_range(0, 3) == 0)) stall($urandom_range(1, 3));
            dq_in   = dq[i];
            rwds_in = mq[i];
            tick();
            if (ca[46]) begin
                if (i == 0) m_cr0 = dq[i];
                chk("regwr_cr0", cr0, m_cr0);
            end else begin
                if (!mq[i][1]) m_mem[a][15:8] = dq[i][15:8];
                if (!mq[i][0]) m_mem[a][7:0] = dq[i][7:0];
                a = next_addr(a, ca[45]);
            end
        end
        rwds_in = 2'b00;
        end_txn();
    endtask

    task automatic do_read(input logic [47:0] ca, input int n, input bit stalls, input int force_at);
        int          a;
        logic [15:0] exp_w;
        logic [15:0] prev;
        a    = ca_addr(ca);
        prev = 16'h0000;
        send_ca(ca);
        latency(stalls);
        chk("rd_dq_oe", dq_oe, 1);
        chk("rd_rwds_oe", rwds_oe, 1);
        for (int i = 0; i < n; i++) begin
            if ((i == force_at) || (stalls && ($urandom_range(0, 3) == 0))) begin
                stall((i == force_at) ? 5 : $urandom_range(1, 3));
                chk("stall_rwds_out", rwds_out, 0);
                chk("stall_dq_oe", dq_oe, 1);
                if (i > 0) chk("stall_hold", dq_out, prev);
            end
            tick();
            if (ca[46]) exp_w = ca[0] ? m_cr0 : ID0;
            else        exp_w = m_mem[a];
            chk("rd_data", dq_out, exp_w);
            chk("rd_strobe", rwds_out, 1);
            prev = exp_w;
            a = next_addr(a, ca[45]);
        end
        end_txn();
    endtask

    initial begin
        logic [15:0] dq[$];
        logic [1:0]  mq[$];
        logic [47:0] ca;

        rstn = 1'b0; csn = 1'b1; ck_en = 1'b0; dq_in = 16'h0000; rwds_in = 2'b00;
        m_cr0 = CR0_RST;
        tick(); tick();
        chk("rst_dq_out", dq_out, 16'h0000);
        chk("rst_dq_oe", dq_oe, 0);
        chk("rst_rwds_out", rwds_out, 0);
        chk("rst_rwds_oe", rwds_oe, 0);
        chk("rst_proto_err", proto_err, 0);
        chk("rst_cr0", cr0, CR0_RST);
        rstn = 1'b1;
        tick();

        // Known memory image
        for (int i = 0; i < DEPTH; i++) begin
            dq.push_back(16'($urandom));
            mq.push_back(2'b00);
        end
        do_write(make_ca(0, 0, 1, 32'h0), dq, mq, 1'b0);

        // Linear write/read at address 4
        dq = '{16'h1111, 16'h2222, 16'h3333}; mq = '{2'b00, 2'b00, 2'b00};
        do_write(48'h2000_0000_0004, dq, mq, 1'b0);
        do_read(48'hA000_0000_0004, 3, 1'b0, -1);

        // Byte mask over 16'h1234
        dq = '{16'h1234}; mq = '{2'b00};
        do_write(make_ca(0, 0, 1, 32'd100), dq, mq, 1'b0);
        dq = '{16'hABCD}; mq = '{2'b10};
        do_write(make_ca(0, 0, 1, 32'd100), dq, mq, 1'b0);
        chk("mask_model", m_mem[100], 16'h12CD);
        do_read(make_ca(1, 0, 1, 32'd100), 1, 1'b0, -1);

        // Wrapped vs linear from address 14
        do_read(make_ca(1, 0, 0, 32'd14), 4, 1'b0, -1);
        do_read(make_ca(1, 0, 1, 32'd14), 4, 1'b0, -1);

        // Register write, then register reads
        dq = '{16'h8F17, 16'h0000}; mq = '{2'b00, 2'b00};
        do_write(48'h6000_0100_0000, dq, mq, 1'b0);
        chk("cr0_after_wr", cr0, 16'h8F17);
        do_read(make_ca(1, 1, 1, 32'h1), 2, 1'b0, -1);
        do_read(make_ca(1, 1, 1, 32'h0), 2, 1'b0, -1);

        // Abort during CA
        ca = make_ca(0, 0, 1, 32'd300);
        csn = 1'b0; ck_en = 1'b1; tick();
        dq_in = ca[47:32]; tick();
        dq_in = ca[31:16]; tick();
        csn = 1'b1; tick();
        chk("abort_ca_perr", proto_err, 1);
        chk("abort_ca_rwds_oe", rwds_oe, 0);
        tick();
        chk("abort_ca_perr_clr", proto_err, 0);

        // Abort during latency
        send_ca(make_ca(0, 0, 1, 32'd300));
        repeat (5) begin dq_in = 16'hDEAD; tick(); end
        csn = 1'b1; tick();
        chk("abort_lat_perr", proto_err, 1);
        tick();
        chk("abort_lat_perr_clr", proto_err, 0);
        do_read(make_ca(1, 0, 1, 32'd300), 1, 1'b0, -1);

        // Write cut short after 2 of 4 words
        dq = '{16'hA5A5, 16'h5A5A}; mq = '{2'b00, 2'b00};
        do_write(make_ca(0, 0, 1, 32'd200), dq, mq, 1'b0);
        do_read(make_ca(1, 0, 1, 32'd200), 4, 1'b0, -1);

        // 5-clk ck_en stall mid-read
        do_read(make_ca(1, 0, 1, 32'd500), 6, 1'b0, 3);

        // Reset mid-read
        send_ca(make_ca(1, 0, 1, 32'd4));
        latency(1'b0);
        tick();
        chk("pre_rst_data", dq_out, m_mem[4]);
        #3;
        rstn = 1'b0;
        csn  = 1'b1;
        #1;
        chk("midrst_dq_oe", dq_oe, 0);
        chk("midrst_rwds_oe", rwds_oe, 0);
        chk("midrst_cr0", cr0, CR0_RST);
        m_cr0 = CR0_RST;
        tick();
        rstn = 1'b1;
        tick();
        do_read(make_ca(1, 0, 1, 32'd4), 3, 1'b0, -1);
        do_read(make_ca(1, 1, 1, 32'h1), 1, 1'b0, -1);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            int          op;
            int          len;
            logic [31:0] ad;
            bit          lin;
            op  = $urandom_range(0, 9);
            len = $urandom_range(1, 20);
            ad  = $urandom;
            lin = 1'($urandom);
            if (op <= 3 || op == 8) begin
                dq.delete(); mq.delete();
                for (int i = 0; i < len; i++) begin
                    dq.push_back(16'($urandom));
                    mq.push_back(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
                end
                do_write(make_ca(0, (op == 8), lin, ad), dq, mq, 1'b1);
            end else begin
                do_read(make_ca(1, (op == 9), lin, ad), len, 1'b1, -1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hyperbus_target_model.md
Name: hyperbus_target_model

Overview:
- Synthesizable HyperRAM device responder: the target end of the HyperBus link that the controller state machine drives.
- Operates at the controller's 16-bit word-per-clock boundary, where one word equals one CK period (both DDR edges), i.e. the same framing the io buffer converts.
- Used in simulation and FPGA loopback to exercise controller reads, writes, latency and burst logic without a physical device.
- Contains a word-addressed memory array, CR0 configuration register, and a fixed-latency countdown.

Parameters:
ADDR_W, 10, word address width; memory depth 2**ADDR_W words
LATENCY, 6, initial latency in CK cycles (1x)
FIXED_2X, 1, 1 = always double latency (2*LATENCY) and drive RWDS high during CA
WRAP_LEN, 16, wrapped-burst length in words (power of 2, 2..64)
ID0, 16'h0C81, value returned for register-space reads with CA[0]=0
CR0_RST, 16'h8F1F, CR0 reset value

Ports:
clk  in  1  system clock (host clk0)
rstn  in  1  asynchronous active-low reset
csn  in  1  chip select, active low
ck_en  in  1  host CK running this cycle; device advances only when csn=0 and ck_en=1
dq_in  in  16  host word ({edge-rise byte, edge-fall byte})
rwds_in  in  2  write byte mask, 1 = byte masked; [1] upper byte, [0] lower byte
dq_out  out  16  read data word
dq_oe  out  1  device drives DQ
rwds_out  out  1  CA phase: latency indicator; RD phase: word-valid strobe
rwds_oe  out  1  device drives RWDS
cr0  out  16  current CR0 value
proto_err  out  1  one-cycle pulse: csn rose during CA or LAT

Behaviour:
- Reset values: state IDLE, dq_out 0, dq_oe 0, rwds_out 0, rwds_oe 0, proto_err 0, cr0 = CR0_RST. Memory contents are not reset.
- A "beat" is a clk with csn=0 and ck_en=1. Nothing advances on non-beat cycles; all outputs hold their values.

State machine (IDLE, CA, LAT, WR, RD, REGWR):
- IDLE → CA on csn falling (csn=0). The word counter clears.
- CA: three beats capture CA[47:32], CA[31:16], CA[15:0] in that order.
  - While in CA: rwds_oe=1 and rwds_out=FIXED_2X.
  - After the third beat, decode the captured CA:
    - Read (CA[47]=1): load the latency counter with L = FIXED_2X ? 2*LATENCY : LATENCY; go to LAT.
    - Memory write (CA[47]=0, CA[46]=0): load L; go to LAT.
    - Register write (CA[47]=0, CA[46]=1): go to REGWR (zero latency).
- LAT: decrement the counter per beat. The beat that consumes count 1 transitions to RD or WR. Exactly L beats of latency.
- Address decode:
  - Start word address = {CA[44:16], CA[2:0]} truncated to ADDR_W.
  - CA[45]=1: linear burst; the address increments by 1 per data beat and wraps modulo 2**ADDR_W.
  - CA[45]=0: wrapped burst; the low log2(WRAP_LEN) bits increment modulo WRAP_LEN, upper bits fixed.
- RD: on each beat, register dq_out <= mem[addr] (or for register space: ID0 if CA[0]=0, else cr0), set rwds_out=1, then advance the address.
  - On non-beat clks in RD, rwds_out=0.
  - dq_oe=1 and rwds_oe=1 throughout RD.
  - The first data word is visible the clk after the beat that completed LAT (1-clk registered latency).
- WR: on each beat, write dq_in[15:8] unless rwds_in[1], and dq_in[7:0] unless rwds_in[0]; advance the address. dq_oe=0, rwds_oe=0.
- REGWR: the first beat loads cr0 <= dq_in; further beats are ignored until csn rises.
- csn=1 in any state → IDLE next clk, with dq_oe=0, rwds_oe=0, rwds_out=0.
  - If the state was CA or LAT, pulse proto_err for 1 clk; no memory or register side effect.
  - If the state was WR, only beats already taken are committed.
- Burst length is unbounded; the host ends a burst only by raising csn.
- ck_en=1 while csn=1 is ignored.
- Reset asserted mid-operation forces all reset values immediately. Memory keeps contents already written.

Test Plan:
- Linear write then read, FIXED_2X=1, LATENCY=6:
  - Write: CA {16'h2000,16'h0000,16'h0004} (write, memory, linear, addr 4), 12 latency beats, data 1111,2222,3333.
  - Read: the same CA with CA[47]=1.
  - Required: dq_out 1111,2222,3333 on consecutive beats; first word one clk after the 12th latency beat; rwds_out=1 per beat.
- Byte mask: write 16'hABCD with rwds_in=2'b10 over existing 16'h1234 → readback 16'h12CD.
- Wrapped read, WRAP_LEN=16, start addr 14: expected address order 14,15,0,1 within group 0; a linear read of the same start gives 14,15,16,17.
- Register path:
  - Register write CA {16'h6000,16'h0100,16'h0000}, one beat 16'h8F17 → cr0=16'h8F17 the next clk, with no latency beats.
  - Register read with CA[0]=1 returns 16'h8F17; with CA[0]=0 returns ID0.
- Abort handling:
  - csn rises after the 2nd CA word → proto_err one-clk pulse, state IDLE, memory unchanged.
  - csn rises after 2 of 4 write beats → only 2 words written.
- ck_en stall and reset:
  - Hold ck_en=0 for 5 clks mid-read → outputs hold, rwds_out=0, and the address does not advance.
  - Assert rstn=0 mid-RD → dq_oe=0, rwds_oe=0 immediately; cr0=CR0_RST.
